fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch sequencer sitting directly downstream of the program counter. Samples the counter's current value, runs a request/acknowledge read against instruction memory, and hands the fetched word to the decoder over a valid/ready handshake. It produces the one-cycle `pc_inc` pulse that advances the counter, and supports a flush so a counter load (jump) discards stale work.

## Interface
- `ADDR_WIDTH`, 8, width of PC and memory address
- `DATA_WIDTH`, 8, instruction word width
- `TIMEOUT`, 15, max WAIT cycles before abort (used only with `FETCH_TIMEOUT_EN`)

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `run`  in  1  permit new fetches
- `pc`  in  ADDR_WIDTH  current program counter value
- `pc_inc`  out  1  one-cycle pulse driving the counter's advance input
- `flush`  in  1  discard in-flight/held instruction (asserted with counter load)
- `mem_addr`  out  ADDR_WIDTH  read address
- `mem_rd`  out  1  read request, held until acknowledged
- `mem_ack`  in  1  read data valid
- `mem_data`  in  DATA_WIDTH  read data
- `instr`  out  DATA_WIDTH  fetched word
- `instr_valid`  out  1  `instr` valid to decoder
- `instr_ready`  in  1  decoder accepts
- `busy`  out  1  high in any state except IDLE
- `fetch_err`  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset → IDLE; all outputs 0.
- IDLE: `run`=1 (and `fetch_err`=0) → REQ.
- REQ (1 cycle): register `mem_addr`<=`pc`, `mem_rd`<=1 → WAIT.
- WAIT: `mem_rd` held, `mem_addr` stable. On `mem_ack`=1: `instr`<=`mem_data`, `mem_rd`<=0, `instr_valid`<=1, `pc_inc`<=1 → HOLD. `mem_ack` ignored in all other states.
- HOLD: `pc_inc` forced 0 (exactly one-cycle pulse). `instr`/`instr_valid` held until `instr_valid`&`instr_ready`; then `instr_valid`<=0 → REQ if `run`, else IDLE.
- Flush: priority reset > flush > normal.
  - REQ or IDLE: no effect (next REQ samples new `pc`).
  - WAIT: sets discard flag; `mem_rd` still held until `mem_ack`; on ack data dropped, no `instr_valid`, no `pc_inc`, → REQ (IDLE if `run`=0). Flush and `mem_ack` in same cycle: data dropped.
  - HOLD: `instr_valid`<=0 → REQ/IDLE per `run`. Flush with `instr_ready` same cycle: transfer counts as done; state result identical.
- `run` dropping mid-fetch: current fetch completes and is handed off; then IDLE.

## Timing
- Zero-wait memory (`mem_ack` first WAIT cycle): `instr_valid` rises 2 cycles after REQ entry; best throughput 3 cycles/instruction.
- `pc_inc` rises same edge as `instr_valid`; counter must settle before next REQ edge (≥1 cycle guaranteed by HOLD).
- `mem_addr` changes only on REQ entry edge; never while `mem_rd`=1.
- Reset mid-fetch: `mem_rd`, `instr_valid`, `pc_inc`, discard flag, `fetch_err` cleared next edge; memory must tolerate abandoned request.

## Configuration
- `FETCH_TIMEOUT_EN` defined: WAIT counter (width $clog2(TIMEOUT+1)), cleared on REQ. If TIMEOUT cycles pass in WAIT without `mem_ack`: `mem_rd`<=0, `fetch_err`<=1 (sticky until reset), no `pc_inc`, → IDLE; IDLE not left while `fetch_err`=1. Ack in the TIMEOUT-th cycle is accepted.
- Undefined: WAIT waits indefinitely; `fetch_err` tied 0; no counter logic.

## Test plan
- Reset, `run`=1, `pc`=0x10, `mem_ack` first WAIT cycle, `mem_data`=0xA5, `instr_ready`=1 → `mem_addr`=0x10, `instr`=0xA5 valid 2 cycles after REQ, single `pc_inc` pulse, next REQ 3 cycles later.
- `mem_ack` after 4 WAIT cycles, `instr_ready` low 3 cycles → `mem_rd` high 4 cycles, `mem_addr` stable, `instr_valid` held 4 cycles, `pc_inc` exactly 1 cycle.
- Flush in WAIT, `pc` changed to 0x40 → ack'd data dropped, no `instr_valid`/`pc_inc`, next `mem_addr`=0x40.
- Flush in HOLD → `instr_valid` low next cycle, REQ follows, `pc_inc` count unchanged.
- `run`=0 during WAIT → fetch completes, handoff, IDLE, `busy`=0; reset mid-WAIT → all outputs 0 next cycle.
- With `FETCH_TIMEOUT_EN`, TIMEOUT=15, no ack → `mem_rd` drops after 15 WAIT cycles, `fetch_err`=1, stays IDLE with `run`=1 until reset; without macro, `mem_rd` held 100+ cycles, `fetch_err`=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: program-counter link, instruction-memory read port and decoder handshake.
// The master side is the sequencer; the slave side is the surrounding counter/memory/decoder.
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  run;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_inc;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  busy;
    logic                  fetch_err;

    modport master (
        input  run, pc, flush, mem_ack, mem_data, instr_ready,
        output pc_inc, mem_addr, mem_rd, instr, instr_valid, busy, fetch_err
    );

    modport slave (
        output run, pc, flush, mem_ack, mem_data, instr_ready,
        input  pc_inc, mem_addr, mem_rd, instr, instr_valid, busy, fetch_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC sample -> memory req/ack read -> valid/ready handoff to decoder.
// Optional WAIT timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_rd;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic                  r_pc_inc;
    logic                  r_discard;
    logic                  w_timeout;
    logic                  w_err_block;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_release;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fetch_err;

    // Counter holds (WAIT cycles elapsed - 1); an ack in the last allowed cycle still wins.
    assign w_timeout   = (r_state == S_WAIT) && !bus.mem_ack && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    assign w_err_block = r_fetch_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (r_state == S_REQ) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign bus.fetch_err = r_fetch_err;
`else
    assign w_timeout     = 1'b0;
    assign w_err_block   = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    // A flush seen during WAIT (now or earlier) turns the eventual ack into a discard.
    assign w_accept  = (r_state == S_WAIT) && bus.mem_ack && !bus.flush && !r_discard;
    assign w_drop    = (r_state == S_WAIT) && bus.mem_ack && (bus.flush || r_discard);
    assign w_release = (r_state == S_HOLD) && (bus.instr_ready || bus.flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.run && !w_err_block) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_accept) begin
                    w_next = S_HOLD;
                end else if (w_drop) begin
                    w_next = bus.run ? S_REQ : S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (w_release) begin
                    w_next = bus.run ? S_REQ : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_inc      <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_pc_inc <= w_accept;
            // Address is latched at the end of REQ so the counter has settled after its advance.
            if (r_state == S_REQ) begin
                r_mem_addr <= bus.pc;
                r_mem_rd   <= 1'b1;
            end else if ((r_state == S_WAIT) && (bus.mem_ack || w_timeout)) begin
                r_mem_rd <= 1'b0;
            end
            if (w_accept) begin
                r_instr       <= bus.mem_data;
                r_instr_valid <= 1'b1;
            end else if (w_release) begin
                r_instr_valid <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                if (bus.mem_ack || w_timeout) begin
                    r_discard <= 1'b0;
                end else if (bus.flush) begin
                    r_discard <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc_inc      = r_pc_inc;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: normal fetch, wait states, back-pressure, flush, run drop,
// reset mid-fetch and the no-ack case (timeout behaviour when FETCH_TIMEOUT_EN is defined).
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_inc = 0;

    fetch_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .TIMEOUT   (15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Number of pc_inc pulses seen, i.e. how far the program counter would have advanced.
    always @(posedge clk) begin
        if (reset) n_inc <= 0;
        else if (bus.pc_inc) n_inc <= n_inc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd_cnt;
        rd_cnt          = 0;
        reset           = 1'b1;
        bus.run         = 1'b0;
        bus.pc          = 8'h00;
        bus.flush       = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_data    = 8'h00;
        bus.instr_ready = 1'b0;
        tick();
        tick();
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_pc_inc", bus.pc_inc, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fetch_err", bus.fetch_err, 0);

        // Zero-wait fetch at 0x10
        reset           = 1'b0;
        bus.run         = 1'b1;
        bus.pc          = 8'h10;
        bus.instr_ready = 1'b1;
        tick();
        chk("t1_req_busy", bus.busy, 1);
        chk("t1_req_rd", bus.mem_rd, 0);
        tick();
        chk("t1_wait_rd", bus.mem_rd, 1);
        chk("t1_addr", bus.mem_addr, 8'h10);
        chk("t1_wait_valid", bus.instr_valid, 0);
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'hA5;
        tick();
        chk("t1_valid", bus.instr_valid, 1);
        chk("t1_instr", bus.instr, 8'hA5);
        chk("t1_pc_inc", bus.pc_inc, 1);
        chk("t1_rd_drop", bus.mem_rd, 0);
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        bus.pc       = 8'h11;
        tick();
        chk("t1_handoff_valid", bus.instr_valid, 0);
        chk("t1_pc_inc_pulse", bus.pc_inc, 0);
        chk("t1_next_req_busy", bus.busy, 1);
        chk("t1_next_req_rd", bus.mem_rd, 0);
        chk("t1_inc_count", n_inc, 1);
        tick();
        chk("t1_next_addr", bus.mem_addr, 8'h11);
        chk("t1_next_rd", bus.mem_rd, 1);

        // Ack on the 4th WAIT cycle, decoder stalls 3 cycles
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_rd_held", bus.mem_rd, 1);
            chk("t2_addr_stable", bus.mem_addr, 8'h11);
            tick();
        end
        chk("t2_rd_4th", bus.mem_rd, 1);
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h3C;
        tick();
        bus.mem_ack = 1'b0;
        bus.pc      = 8'h12;
        chk("t2_pc_inc", bus.pc_inc, 1);
        chk("t2_valid", bus.instr_valid, 1);
        chk("t2_instr", bus.instr, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_valid_held", bus.instr_valid, 1);
            chk("t2_pc_inc_low", bus.pc_inc, 0);
            chk("t2_instr_held", bus.instr, 8'h3C);
        end
        bus.instr_ready = 1'b1;
        tick();
        chk("t2_handoff_valid", bus.instr_valid, 0);
        chk("t2_inc_count", n_inc, 2);
        chk("t2_busy", bus.busy, 1);

        // Flush during WAIT together with a jump to 0x40
        tick();
        chk("t3_addr_old", bus.mem_addr, 8'h12);
        bus.flush = 1'b1;
        bus.pc    = 8'h40;
        tick();
        bus.flush = 1'b0;
        chk("t3_rd_held", bus.mem_rd, 1);
        chk("t3_addr_stable", bus.mem_addr, 8'h12);
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h77;
        tick();
        bus.mem_ack = 1'b0;
        chk("t3_drop_valid", bus.instr_valid, 0);
        chk("t3_drop_pc_inc", bus.pc_inc, 0);
        chk("t3_drop_rd", bus.mem_rd, 0);
        chk("t3_drop_busy", bus.busy, 1);
        tick();
        chk("t3_new_addr", bus.mem_addr, 8'h40);
        chk("t3_new_rd", bus.mem_rd, 1);
        chk("t3_inc_count", n_inc, 2);
        bus.flush    = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h55;
        tick();
        bus.flush   = 1'b0;
        bus.mem_ack = 1'b0;
        chk("t3_same_cyc_valid", bus.instr_valid, 0);
        chk("t3_same_cyc_pc_inc", bus.pc_inc, 0);
        tick();
        chk("t3_refetch_rd", bus.mem_rd, 1);
        chk("t3_refetch_addr", bus.mem_addr, 8'h40);
        chk("t3_inc_count2", n_inc, 2);

        // Flush while the word is held for the decoder
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h99;
        tick();
        bus.mem_ack = 1'b0;
        chk("t4_hold_valid", bus.instr_valid, 1);
        chk("t4_hold_instr", bus.instr, 8'h99);
        bus.pc          = 8'h41;
        bus.instr_ready = 1'b0;
        bus.flush       = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t4_flush_valid", bus.instr_valid, 0);
        chk("t4_flush_busy", bus.busy, 1);
        chk("t4_flush_rd", bus.mem_rd, 0);
        chk("t4_inc_count", n_inc, 3);
        tick();
        chk("t4_next_addr", bus.mem_addr, 8'h41);
        chk("t4_next_rd", bus.mem_rd, 1);

        // run dropped during WAIT: fetch finishes, then IDLE
        bus.run = 1'b0;
        tick();
        chk("t5_still_wait_rd", bus.mem_rd, 1);
        chk("t5_still_busy", bus.busy, 1);
        bus.instr_ready = 1'b1;
        bus.mem_ack     = 1'b1;
        bus.mem_data    = 8'hC3;
        tick();
        bus.mem_ack = 1'b0;
        chk("t5_valid", bus.instr_valid, 1);
        chk("t5_instr", bus.instr, 8'hC3);
        tick();
        chk("t5_idle_busy", bus.busy, 0);
        chk("t5_idle_valid", bus.instr_valid, 0);
        tick();
        chk("t5_idle_stay", bus.busy, 0);
        chk("t5_idle_rd", bus.mem_rd, 0);
        chk("t5_inc_count", n_inc, 4);

        // Reset in WAIT with a pending discard
        bus.run = 1'b1;
        bus.pc  = 8'h50;
        tick();
        tick();
        chk("t6_wait_rd", bus.mem_rd, 1);
        chk("t6_wait_addr", bus.mem_addr, 8'h50);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_rd", bus.mem_rd, 0);
        chk("t6_rst_addr", bus.mem_addr, 0);
        chk("t6_rst_instr", bus.instr, 0);
        chk("t6_rst_valid", bus.instr_valid, 0);
        chk("t6_rst_pc_inc", bus.pc_inc, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_err", bus.fetch_err, 0);
        tick();
        tick();
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h5A;
        tick();
        bus.mem_ack = 1'b0;
        chk("t6_post_rst_valid", bus.instr_valid, 1);
        chk("t6_post_rst_instr", bus.instr, 8'h5A);
        bus.pc = 8'h60;
        tick();
        tick();

        // Memory never acknowledges
        for (int i = 0; i < 130; i++) begin
            if (bus.mem_rd) rd_cnt++;
            tick();
        end
`ifdef FETCH_TIMEOUT_EN
        chk("t7_rd_cycles", rd_cnt, 15);
        chk("t7_err", bus.fetch_err, 1);
        chk("t7_idle", bus.busy, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("t7_stays_idle", bus.busy, 0);
        chk("t7_err_sticky", bus.fetch_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_err_cleared", bus.fetch_err, 0);
`else
        chk("t7_rd_cycles", rd_cnt, 130);
        chk("t7_err", bus.fetch_err, 0);
        chk("t7_busy", bus.busy, 1);
        chk("t7_addr", bus.mem_addr, 8'h60);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
